// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file.
// Holds the clear/run state encoding and the depth calculation.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every array index once, then raises Ready.
// Reset at any time restarts the walk from index 0.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              i_clock,
    input  logic              i_reset,
    output logic              o_clr_active,
    output logic [ADDR_W-1:0] o_clr_addr,
    output logic              o_ready
);

    localparam int                DEPTH    = rf_depth(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_e         r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_ready;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    // Last entry is zeroed on this same edge, so RUN starts next cycle.
                    if (r_clr_cnt == LAST_IDX) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_clr_active = (r_state == CLEAR);
    assign o_clr_addr   = r_clr_cnt;
    assign o_ready      = r_ready;

endmodule

// File: rtl/regfile_param.sv
// General-purpose register bank: one-entry commit stage, optional read bypass,
// register 0 hardwired to zero, hardware clear after reset.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 6,
    parameter int NUM_RD    = 3,
    parameter int BYPASS    = 1,
    parameter int DEBUG_REG = 3
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       Wr_En,
    input  logic [ADDR_W-1:0]          Wr_Addr,
    input  logic [DATA_W-1:0]          Wr_Data,
    input  logic [NUM_RD*ADDR_W-1:0]   Rd_Addr,
    output logic [NUM_RD*DATA_W-1:0]   Rd_Data,
    output logic                       Ready,
    output logic [DATA_W-1:0]          Debug_Data
);

    localparam int                DEPTH   = rf_depth(ADDR_W);
    localparam logic [ADDR_W-1:0] DBG_IDX = ADDR_W'(DEBUG_REG);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } stage_t;

    logic [DATA_W-1:0] r_mem [DEPTH];
    stage_t            r_stage;

    logic              w_clr_active;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_ready;

    regfile_clear_seq #(
        .ADDR_W(ADDR_W)
    ) u_clear_seq (
        .i_clock     (Clock),
        .i_reset     (Reset),
        .o_clr_active(w_clr_active),
        .o_clr_addr  (w_clr_addr),
        .o_ready     (w_ready)
    );

    // Writes to register 0 are dropped here, so the array entry never changes.
    always_ff @(posedge Clock) begin
        if (Reset || !w_ready) begin
            r_stage.valid <= 1'b0;
        end else begin
            r_stage.valid <= Wr_En && (Wr_Addr != '0);
        end
        r_stage.addr <= Wr_Addr;
        r_stage.data <= Wr_Data;
    end

    // A pending stage entry hit by Reset is discarded rather than committed.
    always_ff @(posedge Clock) begin
        if (w_clr_active) begin
            r_mem[w_clr_addr] <= '0;
        end else if (r_stage.valid && !Reset) begin
            r_mem[r_stage.addr] <= r_stage.data;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_rd_addr;
            logic              w_hit;

            assign w_rd_addr = Rd_Addr[gi*ADDR_W +: ADDR_W];
            assign w_hit     = (BYPASS != 0) && r_stage.valid && (r_stage.addr == w_rd_addr);

            assign Rd_Data[gi*DATA_W +: DATA_W] =
                (!w_ready || (w_rd_addr == '0)) ? '0 :
                w_hit                           ? r_stage.data :
                                                  r_mem[w_rd_addr];
        end
    endgenerate

    assign Ready      = w_ready;
    assign Debug_Data = w_ready ? r_mem[DBG_IDX] : '0;

endmodule
